// File: rtl/sp_ram_be.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sp_ram_be                                                  |
// | Description : Single-port synchronous RAM with per-byte write enables,   |
// |               out-of-range detection and a hardware zero-fill sweep that |
// |               runs after reset and on a clr request.                     |
// | Option      : define SP_RAM_OUTREG_EN to add an output register stage    |
// |               (datao/rvalid/err delayed by one more cycle).              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clr    - restart the zero-fill sweep (wins over a same-cycle access)
//   en     - access request, honoured only while ready=1
//   wen    - 1 = write, 0 = read
//   be     - byte write enables, bit i covers datai[8i+7:8i]
//   addr   - word address
//   datai  - write data
//   datao  - read data, holds its value between reads
//   rvalid - one-cycle pulse marking new read data on datao
//   ready  - array initialised and accepting accesses
//   err    - one-cycle pulse for an accepted access with addr >= MEM_DEPTH

module sp_ram_be #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  wen,
  input  logic [DWIDTH/8-1:0]   be,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH-1:0]     datai,
  output logic [DWIDTH-1:0]     datao,
  output logic                  rvalid,
  output logic                  ready,
  output logic                  err
);

  localparam int NB = DWIDTH / 8;
  // Index width just large enough for the array; never wider than addr
  // because MEM_DEPTH <= 2^AWIDTH.
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IW-1:0]   LAST    = IW'(MEM_DEPTH - 1);
  // One extra bit so that MEM_DEPTH == 2^AWIDTH is representable.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   cnt, cnt_nx;

  logic [DWIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic            in_range;
  logic [IW-1:0]   idx;
  logic            acc;
  logic            rd_acc;
  logic            wr_ok;

  logic            rd_valid;
  logic            rd_err;
  logic [DWIDTH-1:0] rd_data;

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign idx      = addr[IW-1:0];
  assign ready    = (state == RUN);
  // clr has priority: an access presented with clr is discarded.
  assign acc      = en & ready & ~clr;
  assign rd_acc   = acc & ~wen;
  assign wr_ok    = acc & wen & in_range;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      INIT: begin
        if (clr) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr) begin
          state_nx = INIT;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = INIT;
        cnt_nx   = '0;
      end
    endcase
  end

  // Array: no reset on the storage itself; the sweep provides the known state.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= datai[8*i +: 8];
        end
      end
    end
  end

  // First read stage. rd_data only moves on a read so datao holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      rd_err   <= acc & ~in_range;
      if (rd_acc) begin
        rd_data <= in_range ? mem[idx] : '0;
      end
    end
  end

`ifdef SP_RAM_OUTREG_EN
  logic            oq_valid;
  logic            oq_err;
  logic [DWIDTH-1:0] oq_data;

  // Extra output stage; clr flushes any pulse still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oq_valid <= 1'b0;
      oq_err   <= 1'b0;
      oq_data  <= '0;
    end else begin
      oq_valid <= rd_valid & ~clr;
      oq_err   <= rd_err & ~clr;
      if (rd_valid && !clr) begin
        oq_data <= rd_data;
      end
    end
  end

  assign datao  = oq_data;
  assign rvalid = oq_valid;
  assign err    = oq_err;
`else
  assign datao  = rd_data;
  assign rvalid = rd_valid;
  assign err    = rd_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sp_ram_be.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sp_ram_be                                               |
// | Description : Self-checking bench for sp_ram_be (DWIDTH=32, AWIDTH=8,    |
// |               MEM_DEPTH=16). Honours SP_RAM_OUTREG_EN for latency.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_sp_ram_be;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DEP = 16;
`ifdef SP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          en;
  logic          wen;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] datai;
  logic [DW-1:0] datao;
  logic          rvalid;
  logic          ready;
  logic          err;

  sp_ram_be #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .MEM_DEPTH(DEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .wen   (wen),
    .be    (be),
    .addr  (addr),
    .datai (datai),
    .datao (datao),
    .rvalid(rvalid),
    .ready (ready),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic          er;
    logic [DW-1:0] d;
  } exp_t;

  typedef struct {
    logic          wen;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[16];
  int   total = 0;
  int   bad   = 0;
  logic m_ready = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus, record the expectation, and compare the
  // oldest expectation once it has reached the output.
  task automatic step(input logic e, input logic w, input logic [3:0] b,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic c, input logic [DW-1:0] x);
    exp_t it;
    exp_t got;
    logic acc;
    acc   = e && m_ready && !c;
    it.rv = acc && !w;
    it.er = acc && (a >= AW'(DEP));
    it.d  = (a >= AW'(DEP)) ? '0 : x;
    en = e; wen = w; be = b; addr = a; datai = d; clr = c;
    q.push_back(it);
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
    m_ready = m_ready && !c;
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    if (q.size() >= LAT) begin
      got = q.pop_front();
      chk("rvalid", {31'd0, rvalid}, {31'd0, got.rv});
      chk("err", {31'd0, err}, {31'd0, got.er});
      if (got.rv) chk("datao", datao, got.d);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < LAT; i++) idle();
  endtask

  // ready must stay low for DEP-1 edges and rise on the DEP-th edge.
  task automatic wait_sweep();
    q.delete();
    for (int i = 1; i <= DEP; i++) begin
      @(posedge clk);
      #1;
      chk("sweep_ready", {31'd0, ready}, {31'd0, (i == DEP)});
      chk("sweep_rvalid", {31'd0, rvalid}, 32'd0);
    end
    m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 8'd3,   32'hAABBCCDD, 32'h0};
    tbl[1]  = '{1'b1, 4'h5, 8'd3,   32'h11223344, 32'h0};
    tbl[2]  = '{1'b0, 4'hF, 8'd3,   32'h0,        32'hAA22CC44};
    tbl[3]  = '{1'b1, 4'hF, 8'd5,   32'h12345678, 32'h0};
    tbl[4]  = '{1'b0, 4'hF, 8'd5,   32'h0,        32'h12345678};
    tbl[5]  = '{1'b1, 4'hF, 8'd20,  32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{1'b0, 4'hF, 8'd20,  32'h0,        32'h0};
    tbl[7]  = '{1'b0, 4'hF, 8'd4,   32'h0,        32'h0};
    tbl[8]  = '{1'b1, 4'h0, 8'd4,   32'hCAFEF00D, 32'h0};
    tbl[9]  = '{1'b0, 4'h3, 8'd4,   32'h0,        32'h0};
    tbl[10] = '{1'b1, 4'hC, 8'd15,  32'hDEADBEEF, 32'h0};
    tbl[11] = '{1'b0, 4'hF, 8'd15,  32'h0,        32'hDEAD0000};
    tbl[12] = '{1'b0, 4'hF, 8'd255, 32'h0,        32'h0};
    tbl[13] = '{1'b1, 4'h2, 8'd10,  32'h01020304, 32'h0};
    tbl[14] = '{1'b0, 4'hF, 8'd10,  32'h0,        32'h00000300};
    tbl[15] = '{1'b0, 4'hF, 8'd3,   32'h0,        32'hAA22CC44};

    rst_n = 1'b0; clr = 1'b0; en = 1'b0; wen = 1'b0;
    be = '0; addr = '0; datai = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_datao", datao, 32'h0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Reset release and initial sweep.
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep();
    for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, 4'hF, AW'(i), '0, 1'b0, 32'h0);
    drain();

    // Table-driven accesses, back-to-back.
    for (int i = 0; i < 16; i++)
      step(1'b1, tbl[i].wen, tbl[i].be, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp);
    drain();

    // Fill, then clr together with a write to addr 2.
    for (int i = 0; i < DEP; i++)
      step(1'b1, 1'b1, 4'hF, AW'(i), 32'h5A5A0001 + DW'(i), 1'b0, '0);
    step(1'b1, 1'b0, 4'hF, 8'd7, '0, 1'b0, 32'h5A5A0008);
    drain();
    step(1'b1, 1'b1, 4'hF, 8'd2, 32'h0BADF00D, 1'b1, '0);
    wait_sweep();
    for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, 4'hF, AW'(i), '0, 1'b0, 32'h0);
    drain();

    // Make datao nonzero, then reset in the middle of a sweep (cnt=7).
    step(1'b1, 1'b1, 4'hF, 8'd9, 32'h87654321, 1'b0, '0);
    step(1'b1, 1'b0, 4'hF, 8'd9, '0, 1'b0, 32'h87654321);
    drain();
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, '0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_datao", datao, 32'h0);
    chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep();
    step(1'b1, 1'b0, 4'hF, 8'd9, '0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 4'hF, 8'd16, '0, 1'b0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
